// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - FPU unit encodings, default pipeline latencies and latency lookup
//
// Purpose : shared definitions for the FPU issue/retire tracker and the core decoder.
// Ports   : none (package).
package fpu_pkg;

    localparam logic [1:0] FU_ADD = 2'd0;
    localparam logic [1:0] FU_MUL = 2'd1;
    localparam logic [1:0] FU_INV = 2'd2;
    localparam logic [1:0] FU_DIV = 2'd3;

    localparam int unsigned LAT_ADD_DEF = 2;
    localparam int unsigned LAT_MUL_DEF = 3;
    localparam int unsigned LAT_INV_DEF = 4;
    localparam int unsigned LAT_DIV_DEF = 9;

    // Issue-to-result latency of a unit; latencies are passed in so that a
    // parameterised instance and the decoder agree on the same values.
    function automatic int unsigned fu_latency(
        input logic [1:0]  unit,
        input int unsigned lat_add,
        input int unsigned lat_mul,
        input int unsigned lat_inv,
        input int unsigned lat_div
    );
        case (unit)
            FU_ADD:  fu_latency = lat_add;
            FU_MUL:  fu_latency = lat_mul;
            FU_INV:  fu_latency = lat_inv;
            default: fu_latency = lat_div;
        endcase
    endfunction

endpackage

// File: rtl/fpu_retire_slots.sv
// rtl/fpu_retire_slots.sv - D-deep shift/insert slot array with per-slot occupancy lookup
//
// Purpose : tracks in-flight FPU ops; slot k holds the op whose result appears k cycles later.
// Ports   : clk, rstn        clock, synchronous active-low reset
//           clear            empty every slot at the edge
//           ins_en           load slot ins_lat-1 at the edge (shift otherwise)
//           ins_lat          latency of the inserted op (1..D)
//           ins_unit, ins_rd unit code and destination of the inserted op
//           look_lat         latency to probe for a collision
//           look_occ         slot look_lat is occupied (0 when look_lat >= D)
//           head_v/unit/rd   contents of slot 0, i.e. the op retiring this cycle
module fpu_retire_slots
    import fpu_pkg::*;
#(
    parameter int unsigned D  = 9,
    parameter int unsigned LW = $clog2(D + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          clear,
    input  logic          ins_en,
    input  logic [LW-1:0] ins_lat,
    input  logic [1:0]    ins_unit,
    input  logic [4:0]    ins_rd,
    input  logic [LW-1:0] look_lat,
    output logic          look_occ,
    output logic          head_v,
    output logic [1:0]    head_unit,
    output logic [4:0]    head_rd
);

    logic [D-1:0] v_q, v_d;
    logic [1:0]   unit_q [D];
    logic [1:0]   unit_d [D];
    logic [4:0]   rd_q   [D];
    logic [4:0]   rd_d   [D];

    always_comb begin
        v_d = '0;
        for (int k = 0; k < D; k++) begin
            unit_d[k] = FU_ADD;
            rd_d[k]   = '0;
        end
        // Shift toward slot 0; the top slot refills with an empty entry.
        for (int k = 0; k < D - 1; k++) begin
            v_d[k]    = v_q[k+1];
            unit_d[k] = unit_q[k+1];
            rd_d[k]   = rd_q[k+1];
        end
        // The inserted op lands one below its latency because it shifts once
        // per cycle on the way to slot 0.
        for (int k = 0; k < D; k++) begin
            if (ins_en && (LW'(k + 1) == ins_lat)) begin
                v_d[k]    = 1'b1;
                unit_d[k] = ins_unit;
                rd_d[k]   = ins_rd;
            end
        end
        if (clear) begin
            v_d = '0;
            for (int k = 0; k < D; k++) begin
                unit_d[k] = FU_ADD;
                rd_d[k]   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            v_q <= '0;
            for (int k = 0; k < D; k++) begin
                unit_q[k] <= FU_ADD;
                rd_q[k]   <= '0;
            end
        end else begin
            v_q <= v_d;
            for (int k = 0; k < D; k++) begin
                unit_q[k] <= unit_d[k];
                rd_q[k]   <= rd_d[k];
            end
        end
    end

    // Slot look_lat is the one that would shift into the insert position.
    always_comb begin
        look_occ = 1'b0;
        for (int k = 0; k < D; k++) begin
            if (LW'(k) == look_lat) begin
                look_occ = v_q[k];
            end
        end
    end

    assign head_v    = v_q[0];
    assign head_unit = unit_q[0];
    assign head_rd   = rd_q[0];

endmodule

// File: rtl/fpu_retire.sv
// rtl/fpu_retire.sv - issue/retire tracker providing valid and tag for untagged FPU pipelines
//
// Purpose : accepts FPU ops when free of register and write-back-slot hazards and strobes
//           wb_valid/wb_unit/wb_rd in exactly the cycle each unit's result appears.
// Ports   : clk, rstn            clock, synchronous active-low reset
//           flush                discard every in-flight op at the edge
//           issue_valid/ready    issue handshake (ready is combinational on issue_*)
//           issue_unit           0=add 1=mul 2=inv 3=div
//           issue_rd/rs1/rs2     destination and sources (rs2 ignored for inv)
//           wb_valid/unit/rd     retiring result strobe, straight from slot 0 registers
//           busy                 pending-destination bitmap
module fpu_retire
    import fpu_pkg::*;
#(
    parameter int unsigned LAT_ADD = LAT_ADD_DEF,
    parameter int unsigned LAT_MUL = LAT_MUL_DEF,
    parameter int unsigned LAT_INV = LAT_INV_DEF,
    parameter int unsigned LAT_DIV = LAT_DIV_DEF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        flush,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [1:0]  issue_unit,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  issue_rs1,
    input  logic [4:0]  issue_rs2,
    output logic        wb_valid,
    output logic [1:0]  wb_unit,
    output logic [4:0]  wb_rd,
    output logic [31:0] busy
);

    localparam int unsigned D  = LAT_DIV;
    localparam int unsigned LW = $clog2(D + 1);

    logic [31:0]   busy_q, busy_d;
    logic [LW-1:0] lat;
    logic          hz_reg;
    logic          hz_slot;
    logic          accept;

    always_comb begin
        lat = LW'(fu_latency(issue_unit, LAT_ADD, LAT_MUL, LAT_INV, LAT_DIV));
    end

    // RAW on either source and WAW on the destination; no bypass exists.
    always_comb begin
        hz_reg = busy_q[issue_rs1]
               | ((issue_unit != FU_INV) & busy_q[issue_rs2])
               | busy_q[issue_rd];
    end

    assign issue_ready = rstn & ~flush & ~hz_reg & ~hz_slot;
    assign accept      = issue_valid & issue_ready;

    // A bit cannot be set and cleared in the same cycle: busy[rd] blocks the issue.
    always_comb begin
        busy_d = busy_q;
        if (wb_valid) begin
            busy_d[wb_rd] = 1'b0;
        end
        if (accept) begin
            busy_d[issue_rd] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

    fpu_retire_slots #(
        .D  (D),
        .LW (LW)
    ) u_slots (
        .clk       (clk),
        .rstn      (rstn),
        .clear     (flush),
        .ins_en    (accept),
        .ins_lat   (lat),
        .ins_unit  (issue_unit),
        .ins_rd    (issue_rd),
        .look_lat  (lat),
        .look_occ  (hz_slot),
        .head_v    (wb_valid),
        .head_unit (wb_unit),
        .head_rd   (wb_rd)
    );

endmodule

// File: tb/tb_fpu_retire.sv
// tb/tb_fpu_retire.sv - scoreboard testbench for fpu_retire
module tb_fpu_retire;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        flush = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_ready;
    logic [1:0]  issue_unit = 2'd0;
    logic [4:0]  issue_rd = 5'd0;
    logic [4:0]  issue_rs1 = 5'd0;
    logic [4:0]  issue_rs2 = 5'd0;
    logic        wb_valid;
    logic [1:0]  wb_unit;
    logic [4:0]  wb_rd;
    logic [31:0] busy;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        int         cyc;
        logic [1:0] unit;
        logic [4:0] rd;
    } exp_t;

    exp_t sb[$];

    fpu_retire dut (
        .clk         (clk),
        .rstn        (rstn),
        .flush       (flush),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_unit  (issue_unit),
        .issue_rd    (issue_rd),
        .issue_rs1   (issue_rs1),
        .issue_rs2   (issue_rs2),
        .wb_valid    (wb_valid),
        .wb_unit     (wb_unit),
        .wb_rd       (wb_rd),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input logic [1:0] u);
        case (u)
            2'd0:    return 2;
            2'd1:    return 3;
            2'd2:    return 4;
            default: return 9;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic sb_push(input int c, input logic [1:0] u, input logic [4:0] rd);
        exp_t e;
        int   i;
        e.cyc  = c;
        e.unit = u;
        e.rd   = rd;
        i = 0;
        while (i < sb.size() && sb[i].cyc <= c) i++;
        sb.insert(i, e);
    endtask

    task automatic sb_drop(input int after);
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc > after) sb.delete(i);
        end
    endtask

    // Monitor: compares every strobe against the scoreboard head.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            n_chk++;
            n_err++;
            $display("FAIL wb_missing: no strobe for rd=%0d due in cycle %0d", sb[0].rd, sb[0].cyc);
            void'(sb.pop_front());
        end
        if (wb_valid === 1'b1) begin
            n_chk++;
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                if (wb_unit !== sb[0].unit || wb_rd !== sb[0].rd) begin
                    n_err++;
                    $display("FAIL wb_data: got unit=%0d rd=%0d expected unit=%0d rd=%0d (cycle %0d)",
                             wb_unit, wb_rd, sb[0].unit, sb[0].rd, cyc);
                end
                void'(sb.pop_front());
            end else begin
                n_err++;
                $display("FAIL wb_unexpected: got strobe unit=%0d rd=%0d expected none (cycle %0d)",
                         wb_unit, wb_rd, cyc);
            end
        end else if (sb.size() > 0 && sb[0].cyc == cyc) begin
            n_chk++;
            n_err++;
            $display("FAIL wb_missing: got wb_valid=%b expected strobe rd=%0d (cycle %0d)",
                     wb_valid, sb[0].rd, cyc);
            void'(sb.pop_front());
        end
    end

    // Called just after a rising edge; returns just after the edge following acceptance.
    task automatic do_issue(input logic [1:0] u, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, output int acc);
        issue_valid = 1'b1;
        issue_unit  = u;
        issue_rd    = rd;
        issue_rs1   = rs1;
        issue_rs2   = rs2;
        acc = -1000;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (issue_ready === 1'b1) begin
                acc = cyc;
                sb_push(cyc + lat_of(u), u, rd);
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
        end
        issue_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int a0, a1, a2;

        // Reset state
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_ready", {31'd0, issue_ready}, 32'd0);
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_busy", busy, 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        check("rst_wb_unit", {30'd0, wb_unit}, 32'd0);
        check("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        check("idle_ready", {31'd0, issue_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Single div: busy[5] during cycles t+1..t+9, clear at t+10
        t = cyc;
        do_issue(2'd3, 5'd5, 5'd1, 5'd2, a0);
        check("div_accept", a0 - t, 32'd0);
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            check("div_busy_set", {31'd0, busy[5]}, 32'd1);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("div_busy_clr", busy, 32'd0);
        idle(2);

        // Back-to-back mul then add collide in write-back; add slips one cycle
        t = cyc;
        do_issue(2'd1, 5'd3, 5'd1, 5'd2, a0);
        do_issue(2'd0, 5'd4, 5'd1, 5'd2, a1);
        check("b2b_mul_accept", a0 - t, 32'd0);
        check("b2b_add_accept", a1 - t, 32'd2);
        idle(6);

        // RAW: add reading a div destination waits for the retire cycle to pass
        t = cyc;
        do_issue(2'd3, 5'd7, 5'd1, 5'd2, a0);
        do_issue(2'd0, 5'd8, 5'd7, 5'd2, a1);
        check("raw_div_accept", a0 - t, 32'd0);
        check("raw_add_accept", a1 - t, 32'd10);
        idle(4);

        // Slot packing: inv, div, mul with no stalls
        t = cyc;
        do_issue(2'd2, 5'd1, 5'd3, 5'd4, a0);
        do_issue(2'd3, 5'd2, 5'd3, 5'd4, a1);
        do_issue(2'd1, 5'd9, 5'd3, 5'd4, a2);
        check("pack_inv_accept", a0 - t, 32'd0);
        check("pack_div_accept", a1 - t, 32'd1);
        check("pack_mul_accept", a2 - t, 32'd2);
        idle(12);

        // Flush in cycle t+4 kills the div; an add offered then is accepted at t+5
        t = cyc;
        do_issue(2'd3, 5'd6, 5'd1, 5'd2, a0);
        check("flush_div_accept", a0 - t, 32'd0);
        idle(3);
        check("flush_cycle", cyc - t, 32'd4);
        flush       = 1'b1;
        issue_valid = 1'b1;
        issue_unit  = 2'd0;
        issue_rd    = 5'd10;
        issue_rs1   = 5'd1;
        issue_rs2   = 5'd2;
        sb_drop(cyc);
        @(negedge clk);
        check("flush_ready", {31'd0, issue_ready}, 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_busy_clr", busy, 32'd0);
        check("flush_ready_after", {31'd0, issue_ready}, 32'd1);
        if (issue_ready === 1'b1) sb_push(cyc + 2, 2'd0, 5'd10);
        @(posedge clk);
        #1;
        issue_valid = 1'b0;
        @(negedge clk);
        check("flush_busy_new", busy, 32'h0000_0400);
        idle(12);

        // Reset with three ops in flight drops them all
        t = cyc;
        do_issue(2'd3, 5'd13, 5'd1, 5'd2, a0);
        do_issue(2'd1, 5'd12, 5'd1, 5'd2, a1);
        do_issue(2'd2, 5'd11, 5'd1, 5'd2, a2);
        check("rst3_accepts", (a2 - a0), 32'd2);
        check("rst3_busy", busy, 32'h0000_3800);
        issue_unit = 2'd0;
        issue_rd   = 5'd20;
        issue_rs1  = 5'd21;
        issue_rs2  = 5'd22;
        rstn = 1'b0;
        sb_drop(cyc);
        @(negedge clk);
        check("rst3_ready_low", {31'd0, issue_ready}, 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        check("rst3_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst3_wb_unit", {30'd0, wb_unit}, 32'd0);
        check("rst3_wb_rd", {27'd0, wb_rd}, 32'd0);
        check("rst3_busy", busy, 32'd0);
        idle(12);

        check("sb_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
